// File: rtl/winograd_tile_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : winograd_tile_loader_if
//  Description : Bundle of control, memory-read and PE-side signals of the
//                Winograd tile loader. The master modport is the loader
//                itself. The slave modport is the surrounding system, which
//                holds the memories, the PE and the start logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface winograd_tile_loader_if #(
  parameter int KERNEL_SIZE       = 3,
  parameter int INPUT_TILE_SIZE   = 4,
  parameter int CHANNELS          = 3,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH        = 10
);
  localparam int c_N_IN  = INPUT_TILE_SIZE * INPUT_TILE_SIZE * CHANNELS;
  localparam int c_N_KER = KERNEL_SIZE * KERNEL_SIZE * CHANNELS;

  // Control
  logic                                   start;
  logic                                   reload_kernel;
  logic [ADDR_WIDTH-1:0]                  in_base_addr;
  logic [ADDR_WIDTH-1:0]                  ker_base_addr;
  logic                                   busy;
  logic                                   done;
  logic                                   out_xored;
  // Input tile memory
  logic                                   in_en;
  logic [ADDR_WIDTH-1:0]                  in_addr;
  logic [INPUT_DATA_WIDTH-1:0]            in_rdata;
  // Kernel memory
  logic                                   ker_en;
  logic [ADDR_WIDTH-1:0]                  ker_addr;
  logic [KERNEL_DATA_WIDTH-1:0]           ker_rdata;
  // PE side
  logic [c_N_IN*INPUT_DATA_WIDTH-1:0]     inpData;
  logic [c_N_KER*KERNEL_DATA_WIDTH-1:0]   Kernel;
  logic                                   pe_valid;
  logic                                   pe_ready;

  modport master (
    input  start, reload_kernel, in_base_addr, ker_base_addr,
    input  in_rdata, ker_rdata, pe_ready,
    output in_en, in_addr, ker_en, ker_addr,
    output inpData, Kernel, pe_valid, busy, done, out_xored
  );

  modport slave (
    output start, reload_kernel, in_base_addr, ker_base_addr,
    output in_rdata, ker_rdata, pe_ready,
    input  in_en, in_addr, ker_en, ker_addr,
    input  inpData, Kernel, pe_valid, busy, done, out_xored
  );
endinterface
`default_nettype wire

// File: rtl/winograd_tile_loader.sv
`default_nettype none
// ============================================================================
//  Module      : winograd_tile_loader
//  Description : Fetches one input tile and, when needed, one kernel from two
//                synchronous-read memories with read latency RD_LATENCY. It
//                packs them MSB-first into flat buses and presents them to
//                the PE under a valid/ready handshake. The kernel stays
//                resident across tiles unless a reload is requested.
//  Options     : TILE_LOADER_CHECKSUM_EN - when defined, out_xored holds the
//                XOR-reduction of {inpData, Kernel}, loaded on PRESENT entry.
//                When undefined, out_xored is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module winograd_tile_loader #(
  parameter int KERNEL_SIZE       = 3,
  parameter int INPUT_TILE_SIZE   = 4,
  parameter int CHANNELS          = 3,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH        = 10,
  parameter int RD_LATENCY        = 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  winograd_tile_loader_if.master     bus
);

  localparam int c_N_IN    = INPUT_TILE_SIZE * INPUT_TILE_SIZE * CHANNELS;
  localparam int c_N_KER   = KERNEL_SIZE * KERNEL_SIZE * CHANNELS;
  localparam int c_N_MAX   = (c_N_IN > c_N_KER) ? c_N_IN : c_N_KER;
  localparam int c_CW      = $clog2(c_N_MAX + 1);
  localparam int c_IN_TOT  = c_N_IN * INPUT_DATA_WIDTH;
  localparam int c_KER_TOT = c_N_KER * KERNEL_DATA_WIDTH;
  localparam int c_DW      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [c_CW-1:0] c_N_IN_CNT   = c_CW'(c_N_IN);
  localparam logic [c_CW-1:0] c_N_KER_CNT  = c_CW'(c_N_KER);
  localparam logic [c_CW-1:0] c_LAST_IN    = c_CW'(c_N_IN - 1);
  localparam logic [c_CW-1:0] c_LAST_KER   = c_CW'(c_N_MAX - 1);
  localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DRAIN   = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  // One tag per issued read, travelling alongside the memory latency.
  typedef struct packed {
    logic            vin;
    logic            vker;
    logic [c_CW-1:0] idx;
  } tag_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_in_base;
  logic [ADDR_WIDTH-1:0]   r_ker_base;
  logic                    r_ld_ker;
  logic                    r_kernel_loaded;
  logic [c_CW-1:0]         r_cnt;
  logic [c_CW-1:0]         w_cnt_last;
  logic [c_DW-1:0]         r_drain;
  tag_t                    r_tag [RD_LATENCY];
  tag_t                    w_ret;
  logic [c_IN_TOT-1:0]     r_inp;
  logic [c_IN_TOT-1:0]     w_inp_nxt;
  logic [c_KER_TOT-1:0]    r_ker;
  logic [c_KER_TOT-1:0]    w_ker_nxt;
  logic                    r_done;
  logic                    w_in_en;
  logic                    w_ker_en;
  logic                    w_start_acc;
  logic                    w_fetch_last;
  logic                    w_enter_present;
  logic                    w_handshake;

  // A kernel load stretches the fetch phase to the longer of the two streams.
  assign w_cnt_last = (r_ld_ker && (c_N_KER > c_N_IN)) ? c_LAST_KER : c_LAST_IN;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic plus the read strobes and the phase-transition events.
  always_comb begin
    w_state_nxt     = r_state;
    w_in_en         = 1'b0;
    w_ker_en        = 1'b0;
    w_start_acc     = 1'b0;
    w_fetch_last    = 1'b0;
    w_enter_present = 1'b0;
    w_handshake     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_in_en  = (r_cnt < c_N_IN_CNT);
        w_ker_en = r_ld_ker && (r_cnt < c_N_KER_CNT);
        if (r_cnt == w_cnt_last) begin
          w_fetch_last = 1'b1;
          w_state_nxt  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain == c_DRAIN_LAST) begin
          w_enter_present = 1'b1;
          w_state_nxt     = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.pe_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the request context when a start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_base  <= '0;
      r_ker_base <= '0;
      r_ld_ker   <= 1'b0;
    end else if (w_start_acc) begin
      r_in_base  <= bus.in_base_addr;
      r_ker_base <= bus.ker_base_addr;
      r_ld_ker   <= bus.reload_kernel | ~r_kernel_loaded;
    end
  end

  // The kernel becomes resident once a kernel fetch has fully retired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           r_kernel_loaded <= 1'b0;
    else if (w_enter_present && r_ld_ker) r_kernel_loaded <= 1'b1;
  end

  // The fetch index restarts at each accepted start and steps every FETCH cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_cnt <= '0;
    else if (w_start_acc)        r_cnt <= '0;
    else if (r_state == S_FETCH) r_cnt <= r_cnt + 1'b1;
  end

  // The drain counter covers the read latency after the last issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_drain <= '0;
    else if (w_fetch_last)       r_drain <= '0;
    else if (r_state == S_DRAIN) r_drain <= r_drain + 1'b1;
  end

  // The first tag stage records what is issued this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tag[0] <= '0;
    else       r_tag[0] <= '{vin: w_in_en, vker: w_ker_en, idx: r_cnt};
  end

  generate
    if (RD_LATENCY > 1) begin : g_tag_pipe
      for (genvar s = 1; s < RD_LATENCY; s++) begin : g_stage
        // Later stages delay the tag so it meets its data at the memory output.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) r_tag[s] <= '0;
          else       r_tag[s] <= r_tag[s-1];
        end
      end
    end
  endgenerate

  assign w_ret = r_tag[RD_LATENCY-1];

  // Element i lands in the slot for i, so address base+0 sits in the MSBs.
  generate
    for (genvar j = 0; j < c_N_IN; j++) begin : g_in_slot
      assign w_inp_nxt[c_IN_TOT-1-j*INPUT_DATA_WIDTH -: INPUT_DATA_WIDTH] =
        (w_ret.vin && (w_ret.idx == c_CW'(j))) ? bus.in_rdata
                                               : r_inp[c_IN_TOT-1-j*INPUT_DATA_WIDTH -: INPUT_DATA_WIDTH];
    end
    for (genvar j = 0; j < c_N_KER; j++) begin : g_ker_slot
      assign w_ker_nxt[c_KER_TOT-1-j*KERNEL_DATA_WIDTH -: KERNEL_DATA_WIDTH] =
        (w_ret.vker && (w_ret.idx == c_CW'(j))) ? bus.ker_rdata
                                                : r_ker[c_KER_TOT-1-j*KERNEL_DATA_WIDTH -: KERNEL_DATA_WIDTH];
    end
  endgenerate

  // Packed buses change only when a tagged read retires. A skipped kernel
  // load therefore leaves Kernel bit-exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inp <= '0;
      r_ker <= '0;
    end else begin
      r_inp <= w_inp_nxt;
      r_ker <= w_ker_nxt;
    end
  end

  // done pulses for the one cycle after the PE handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_handshake;
  end

`ifdef TILE_LOADER_CHECKSUM_EN
  logic r_xored;

  // The checksum uses the post-capture values, so the final retiring element is included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_xored <= 1'b0;
    else if (w_enter_present) r_xored <= ^{w_inp_nxt, w_ker_nxt};
  end

  assign bus.out_xored = r_xored;
`else
  assign bus.out_xored = 1'b0;
`endif

  // Addresses are forced to zero when their strobe is low.
  assign bus.in_en    = w_in_en;
  assign bus.in_addr  = w_in_en  ? (r_in_base  + ADDR_WIDTH'(r_cnt)) : '0;
  assign bus.ker_en   = w_ker_en;
  assign bus.ker_addr = w_ker_en ? (r_ker_base + ADDR_WIDTH'(r_cnt)) : '0;
  assign bus.inpData  = r_inp;
  assign bus.Kernel   = r_ker;
  assign bus.pe_valid = (r_state == S_PRESENT);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: doc/winograd_tile_loader.md
# winograd_tile_loader

Parametrised successor to the single-shot Winograd PE front end. Per `start`, fetches one input tile (INPUT_TILE_SIZE² × CHANNELS elements) and optionally one kernel (KERNEL_SIZE² × CHANNELS elements) from two synchronous-read memories, honouring a configurable read latency. Packs both into the flattened buses the PE consumes and presents them under a valid/ready handshake. Sits between the input/kernel BRAMs and `PE`; the kernel stays resident across tiles unless a reload is requested.

## Interface
- KERNEL_SIZE, 3, kernel edge
- INPUT_TILE_SIZE, 4, input tile edge
- CHANNELS, 3, channel count
- INPUT_DATA_WIDTH, 8, input element width
- KERNEL_DATA_WIDTH, 8, kernel element width
- ADDR_WIDTH, 10, memory address width
- RD_LATENCY, 1, memory read latency in cycles (≥1)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request one tile load; sampled only in IDLE
- reload_kernel  in  1  sampled with `start`; 1 = refetch kernel
- in_base_addr  in  ADDR_WIDTH  input tile base address, sampled with `start`
- ker_base_addr  in  ADDR_WIDTH  kernel base address, sampled with `start`
- in_en / in_addr  out  1 / ADDR_WIDTH  input memory read strobe/address
- in_rdata  in  INPUT_DATA_WIDTH  input memory data
- ker_en / ker_addr  out  1 / ADDR_WIDTH  kernel memory read strobe/address
- ker_rdata  in  KERNEL_DATA_WIDTH  kernel memory data
- inpData  out  N_IN·INPUT_DATA_WIDTH  packed tile, N_IN = INPUT_TILE_SIZE²·CHANNELS
- Kernel  out  N_KER·KERNEL_DATA_WIDTH  packed kernel, N_KER = KERNEL_SIZE²·CHANNELS
- pe_valid  out  1  packed buses valid
- pe_ready  in  1  PE accepts
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after handshake
- out_xored  out  1  checksum (see Configuration)

## Operation
- FSM: IDLE → FETCH → DRAIN → PRESENT → IDLE.
- IDLE: `start`=1 latches the base addresses and `ld_ker` = reload_kernel OR !kernel_loaded; the next state is FETCH.
- FETCH: counter k = 0..N−1, with N = max(N_IN, ld_ker ? N_KER : 0).
  - in_en=1, in_addr=in_base+k while k<N_IN.
  - ker_en=1, ker_addr=ker_base+k while ld_ker and k<N_KER.
  - Strobes are 0 otherwise.
- Capture: a RD_LATENCY-deep tag pipeline carries (valid, index) per issued read. Element with index i lands in slot [TOTAL−1−i·W −: W] (address base+0 in the MSBs).
- DRAIN: RD_LATENCY cycles with no issues, until the last tag retires. Then PRESENT, and set kernel_loaded when ld_ker.
- PRESENT: pe_valid=1. inpData/Kernel are held stable until pe_valid&pe_ready, then `done` pulses for one cycle and the FSM returns to IDLE.
- Skipped kernel load: the Kernel bus keeps its previous contents bit-exact.
- `start` outside IDLE is ignored, not queued. pe_ready outside PRESENT is ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values:
  - pe_valid, done, busy, in_en, ker_en, out_xored = 0.
  - in_addr, ker_addr = 0.
  - inpData, Kernel = 0.
  - kernel_loaded = 0; state = IDLE.
- The first strobe is asserted in the cycle after the `start` edge.
- `start` edge to pe_valid rising is N + RD_LATENCY cycles (defaults: 48+1 = 49).
- pe_ready high at the first PRESENT cycle gives pe_valid for exactly 1 cycle; `done` rises on the same edge pe_valid falls.
- A new `start` is accepted at the earliest in the cycle `done` is high (state is already IDLE).
- `reset` during any state clears everything immediately, including kernel_loaded; in-flight reads are discarded.

## Configuration
- TILE_LOADER_CHECKSUM_EN defined:
  - out_xored is a register loaded on entry to PRESENT with ^{inpData,Kernel} (post-capture values).
  - It holds until the next PRESENT entry.
- Undefined: out_xored is tied 0 and the reduction logic is absent. All other behaviour is identical.

## Test plan
- Reset then `start`, reload_kernel=0, bases 0/0, mem[i]=i+1, RD_LATENCY=1:
  - Kernel fetched anyway; pe_valid at cycle 49.
  - inpData MSB byte = 0x01, LSB byte = 0x30; Kernel MSB = 0x01, LSB = 0x1B.
- Second `start` with reload_kernel=0, in_base=48:
  - ker_en never asserted; Kernel unchanged.
  - inpData MSB = 0x31.
- pe_ready held low 10 cycles in PRESENT:
  - pe_valid and buses stable all 10 cycles.
  - done pulses once, exactly one cycle after pe_ready rises.
- RD_LATENCY=3, CHANNELS=1, INPUT_TILE_SIZE=6, KERNEL_SIZE=3:
  - N=36; pe_valid at cycle 39; packing correct.
- Assert reset at FETCH k=20, release, restart:
  - all outputs 0 during reset; kernel refetched despite reload_kernel=0.
- With TILE_LOADER_CHECKSUM_EN, all mem bytes 0x01, defaults:
  - 75 odd-parity bytes, so out_xored=1.
  - Without the macro, out_xored stays 0.
